// File: rtl/multi_key_debounce_if.sv
// Key-pin / debounced-event bundle between board pins and the key conditioner.
// The release pulse is named key_release because "release" is a reserved SystemVerilog keyword.
interface multi_key_debounce_if #(
    parameter int CH = 4
);
    logic [CH-1:0] key;
    logic [CH-1:0] key_value;
    logic [CH-1:0] press;
    logic [CH-1:0] key_release;
    logic [CH-1:0] long_press;

    modport master (
        output key,
        input  key_value,
        input  press,
        input  key_release,
        input  long_press
    );

    modport slave (
        input  key,
        output key_value,
        output press,
        output key_release,
        output long_press
    );
endinterface

// File: rtl/multi_key_debounce.sv
// Multi-channel push-button conditioner: per-key synchroniser, lock-out debouncer
// and press / release / long-press event pulses derived from the debounced level.
module multi_key_debounce #(
    parameter int CH          = 4,
    parameter int LOCK_CYCLES = 1000000,
    parameter int LONG_CYCLES = 50000000,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    multi_key_debounce_if.slave  kif
);
    localparam int LOCK_W = $clog2(LOCK_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);
    localparam logic REL = (ACTIVE_LOW != 0);

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    logic [CH-1:0] kv_vec;
    logic [CH-1:0] press_vec;
    logic [CH-1:0] rel_vec;
    logic [CH-1:0] long_vec;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            state_t                 state_reg, state_next;
            logic [LOCK_W-1:0]      lock_cnt_reg, lock_cnt_next;
            logic [HOLD_W-1:0]      hold_cnt_reg, hold_cnt_next;
            logic                   kv_reg, kv_next;
            logic                   press_reg, press_next;
            logic                   rel_reg, rel_next;
            logic                   long_reg, long_next;
            logic                   long_done_reg, long_done_next;

            assign s = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    sync_reg      <= {SYNC_STAGES{REL}};
                    state_reg     <= ST_IDLE;
                    lock_cnt_reg  <= '0;
                    hold_cnt_reg  <= '0;
                    kv_reg        <= REL;
                    press_reg     <= 1'b0;
                    rel_reg       <= 1'b0;
                    long_reg      <= 1'b0;
                    long_done_reg <= 1'b0;
                end else begin
                    sync_reg      <= {sync_reg[SYNC_STAGES-2:0], kif.key[gi]};
                    state_reg     <= state_next;
                    lock_cnt_reg  <= lock_cnt_next;
                    hold_cnt_reg  <= hold_cnt_next;
                    kv_reg        <= kv_next;
                    press_reg     <= press_next;
                    rel_reg       <= rel_next;
                    long_reg      <= long_next;
                    long_done_reg <= long_done_next;
                end
            end

            always_comb begin
                state_next     = state_reg;
                lock_cnt_next  = lock_cnt_reg;
                kv_next        = kv_reg;
                press_next     = 1'b0;
                rel_next       = 1'b0;
                hold_cnt_next  = hold_cnt_reg;
                long_next      = 1'b0;
                long_done_next = long_done_reg;

                // Accept a change at once, then ignore the pin for the whole window.
                case (state_reg)
                    ST_IDLE: begin
                        if (s != kv_reg) begin
                            kv_next       = s;
                            press_next    = (s != REL);
                            rel_next      = (s == REL);
                            lock_cnt_next = '0;
                            state_next    = ST_LOCK;
                        end
                    end
                    ST_LOCK: begin
                        if (lock_cnt_reg == LOCK_MAX) begin
                            lock_cnt_next = '0;
                            state_next    = ST_IDLE;
                        end else begin
                            lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase

                // Hold counter saturates; long_done keeps the long pulse to one per press.
                if (kv_reg == REL) begin
                    hold_cnt_next  = '0;
                    long_done_next = 1'b0;
                end else if (hold_cnt_reg == HOLD_MAX) begin
                    if (!long_done_reg) begin
                        long_next      = 1'b1;
                        long_done_next = 1'b1;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end

            assign kv_vec[gi]    = kv_reg;
            assign press_vec[gi] = press_reg;
            assign rel_vec[gi]   = rel_reg;
            assign long_vec[gi]  = long_reg;
        end
    endgenerate

    assign kif.key_value   = kv_vec;
    assign kif.press       = press_vec;
    assign kif.key_release = rel_vec;
    assign kif.long_press  = long_vec;
endmodule
